// File: rtl/rgb_pwm_driver_if.sv
// rtl/rgb_pwm_driver_if.sv - colour/duty/blink inputs and LED pin outputs of rgb_pwm_driver
interface rgb_pwm_driver_if #(
  parameter int CNT_W = 8
);
  logic             red_in;
  logic             green_in;
  logic             blue_in;
  logic [CNT_W-1:0] duty;
  logic             blink_en;
  logic             led_r;
  logic             led_g;
  logic             led_b;
  logic             period_start;

  // Upstream side: decoder decisions and brightness/blink controls in, LED pins back
  modport master (
    output red_in, green_in, blue_in, duty, blink_en,
    input  led_r, led_g, led_b, period_start
  );

  // Driver side
  modport slave (
    input  red_in, green_in, blue_in, duty, blink_en,
    output led_r, led_g, led_b, period_start
  );
endinterface

// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - PWM-dimmed, optionally blinking RGB LED driver; RGB_PWM_GAMMA_EN selects squared duty
module rgb_pwm_driver #(
  parameter int CNT_W         = 8,
  parameter int PRESCALE      = 4,
  parameter int BLINK_PERIODS = 64
) (
  input  logic            clk,
  input  logic            rst,
  rgb_pwm_driver_if.slave io
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BC_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_PERIODS - 1);

  typedef enum logic [1:0] {
    SOLID     = 2'd0,
    BLINK_ON  = 2'd1,
    BLINK_OFF = 2'd2
  } state_t;

  logic [PS_W-1:0]  ps_q;
  logic [CNT_W-1:0] pwm_cnt;
  logic [2:0]       col_q;
  logic [CNT_W-1:0] duty_q;
  logic [CNT_W-1:0] duty_nxt;
  logic [BC_W-1:0]  blink_cnt, blink_cnt_nxt;
  state_t           state, state_nxt;
  logic             tick, boundary, on_phase, lit;
  logic             led_r_q, led_g_q, led_b_q, period_start_q;

  assign tick     = (ps_q == PS_LAST);
  assign boundary = tick && (pwm_cnt == {CNT_W{1'b1}});
  assign lit      = on_phase && (pwm_cnt < duty_q);

`ifdef RGB_PWM_GAMMA_EN
  // Square the requested duty and keep the upper half: approximate gamma-2 curve
  logic [2*CNT_W-1:0] duty_sq;
  assign duty_sq  = {{CNT_W{1'b0}}, io.duty} * {{CNT_W{1'b0}}, io.duty};
  assign duty_nxt = CNT_W'(duty_sq >> CNT_W);
`else
  assign duty_nxt = io.duty;
`endif

  // Prescaler: divides clk down to the PWM tick rate
  always_ff @(posedge clk) begin
    if (rst)       ps_q <= '0;
    else if (tick) ps_q <= '0;
    else           ps_q <= ps_q + 1'b1;
  end

  // PWM counter, boundary pulse and shadow capture so changes land only on period edges
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt        <= '0;
      period_start_q <= 1'b0;
      col_q          <= 3'b000;
      duty_q         <= '0;
    end else begin
      period_start_q <= boundary;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (boundary) begin
        col_q  <= {io.red_in, io.green_in, io.blue_in};
        duty_q <= duty_nxt;
      end
    end
  end

  // Registered LED pins, one clock behind pwm_cnt
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r_q <= 1'b0;
      led_g_q <= 1'b0;
      led_b_q <= 1'b0;
    end else begin
      led_r_q <= col_q[2] & lit;
      led_g_q <= col_q[1] & lit;
      led_b_q <= col_q[0] & lit;
    end
  end

  // Blink FSM state register, advanced only at period boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SOLID;
      blink_cnt <= '0;
    end else if (boundary) begin
      state     <= state_nxt;
      blink_cnt <= blink_cnt_nxt;
    end
  end

  // Blink FSM next state; dropping blink_en takes priority over the half-phase wrap
  always_comb begin
    state_nxt     = state;
    blink_cnt_nxt = blink_cnt;
    case (state)
      SOLID: begin
        if (io.blink_en) begin
          state_nxt     = BLINK_ON;
          blink_cnt_nxt = '0;
        end
      end
      BLINK_ON, BLINK_OFF: begin
        if (!io.blink_en) begin
          state_nxt = SOLID;
        end else if (blink_cnt == BC_LAST) begin
          state_nxt     = (state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
          blink_cnt_nxt = '0;
        end else begin
          blink_cnt_nxt = blink_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt     = SOLID;
        blink_cnt_nxt = '0;
      end
    endcase
  end

  // Blink FSM output: LED allowed on except in the dark half-phase
  always_comb begin
    on_phase = 1'b1;
    if (state == BLINK_OFF) on_phase = 1'b0;
  end

  assign io.led_r        = led_r_q;
  assign io.led_g        = led_g_q;
  assign io.led_b        = led_b_q;
  assign io.period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb/tb_rgb_pwm_driver.sv - directed-vector bench for rgb_pwm_driver
module tb_rgb_pwm_driver;

  localparam int CNT_W         = 4;
  localparam int PRESCALE      = 2;
  localparam int BLINK_PERIODS = 2;
  localparam int PER           = PRESCALE * (1 << CNT_W);

`ifdef RGB_PWM_GAMMA_EN
  localparam int H4  = 2;
  localparam int H8  = 8;
  localparam int H15 = 28;
`else
  localparam int H4  = 8;
  localparam int H8  = 16;
  localparam int H15 = 30;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rgb_pwm_driver_if #(.CNT_W(CNT_W)) bus ();

  rgb_pwm_driver #(
    .CNT_W(CNT_W),
    .PRESCALE(PRESCALE),
    .BLINK_PERIODS(BLINK_PERIODS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the first period_start after reset release; LEDs must stay dark
  task automatic wait_first_start(input string tag);
    int lat;
    int on_cnt;
    lat    = -1;
    on_cnt = 0;
    for (int i = 1; i <= 2 * PER; i++) begin
      @(negedge clk);
      if (bus.period_start) begin
        lat = i;
        break;
      end
      on_cnt += int'(bus.led_r) + int'(bus.led_g) + int'(bus.led_b);
    end
    check({tag, "_latency"}, lat, PER);
    check({tag, "_dark"}, on_cnt, 0);
  endtask

  // Observes one full period starting from a period_start negedge.
  // kind 1: switch red->blue at cycle sw_at; kind 2: drop blink_en at cycle sw_at.
  task automatic run_period(input string tag, input int exp_r, input int exp_g, input int exp_b,
                            input int sw_at, input int kind);
    int r, g, b, ps, ps_at, first, last;
    r = 0; g = 0; b = 0; ps = 0; ps_at = -1; first = -1; last = -1;
    for (int i = 1; i <= PER; i++) begin
      @(negedge clk);
      r += int'(bus.led_r);
      g += int'(bus.led_g);
      b += int'(bus.led_b);
      if (bus.led_r | bus.led_g | bus.led_b) begin
        if (first < 0) first = i;
        last = i;
      end
      if (bus.period_start) begin
        ps++;
        ps_at = i;
      end
      if (i == sw_at) begin
        if (kind == 1) begin
          bus.red_in  = 1'b0;
          bus.blue_in = 1'b1;
        end else if (kind == 2) begin
          bus.blink_en = 1'b0;
        end
      end
    end
    check({tag, "_r"}, r, exp_r);
    check({tag, "_g"}, g, exp_g);
    check({tag, "_b"}, b, exp_b);
    check({tag, "_ps_count"}, ps, 1);
    check({tag, "_ps_at"}, ps_at, PER);
    if (exp_r + exp_g + exp_b > 0) begin
      check({tag, "_first"}, first, 1);
      check({tag, "_last"}, last, exp_r + exp_g + exp_b);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.red_in   = 1'b0;
    bus.green_in = 1'b0;
    bus.blue_in  = 1'b0;
    bus.duty     = '0;
    bus.blink_en = 1'b0;

    // Reset and first boundary
    repeat (3) @(negedge clk);
    check("rst_led_r", int'(bus.led_r), 0);
    check("rst_led_g", int'(bus.led_g), 0);
    check("rst_led_b", int'(bus.led_b), 0);
    check("rst_ps", int'(bus.period_start), 0);
    bus.red_in = 1'b1;
    bus.duty   = 4'd4;
    rst        = 1'b0;
    wait_first_start("first");

    // Basic dimming
    run_period("dim4", H4, 0, 0, 0, 0);

    // Duty extremes; each change shows up one period later
    bus.duty = 4'd0;
    run_period("dim4_hold", H4, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) run_period("duty0", 0, 0, 0, 0, 0);
    bus.duty = 4'd15;
    run_period("duty0_hold", 0, 0, 0, 0, 0);
    run_period("duty15", H15, 0, 0, 0, 0);

    // Mid-period colour change
    run_period("midchg", H15, 0, 0, 10, 1);
    run_period("blue15", 0, 0, H15, 0, 0);

    // Blink: two lit periods, two dark, then drop blink_en while dark
    bus.blink_en = 1'b1;
    bus.duty     = 4'd8;
    run_period("blink_pre", 0, 0, H15, 0, 0);
    run_period("blink_on0", 0, 0, H8, 0, 0);
    run_period("blink_on1", 0, 0, H8, 0, 0);
    run_period("blink_off0", 0, 0, 0, 0, 0);
    run_period("blink_off1", 0, 0, 0, 0, 0);
    run_period("blink_on2", 0, 0, H8, 0, 0);
    run_period("blink_on3", 0, 0, H8, 0, 0);
    run_period("blink_off2", 0, 0, 0, 10, 2);
    run_period("solid0", 0, 0, H8, 0, 0);
    run_period("solid1", 0, 0, H8, 0, 0);

    // Reset mid-pulse
    bus.red_in  = 1'b1;
    bus.blue_in = 1'b0;
    run_period("back_blue", 0, 0, H8, 0, 0);
    repeat (3) @(negedge clk);
    check("pre_rst_led_r", int'(bus.led_r), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_led_r", int'(bus.led_r), 0);
    check("midrst_ps", int'(bus.period_start), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_first_start("restart");
    run_period("restart_red", H8, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
